alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational Arithmetic/logic unit instance between two requesters (e.g. the execute stage and a multi-cycle helper such as an address generator).
- Accepts an operation from one requester via a valid/ready handshake and latches its operands.
- Drives the ALU for one cycle and registers result/zero.
- Returns the result to the owning requester via a valid/ready response handshake, with round-robin fairness between requesters.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- OP_WIDTH, 5, width of op and shamt fields.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- reqN_valid  in  1  request N (N=0,1) presents an operation.
- reqN_ready  out  1  arbiter accepts request N this cycle.
- reqN_op  in  OP_WIDTH  ALU op code for request N.
- reqN_shamt  in  OP_WIDTH  shift amount for request N.
- reqN_data_1  in  DATA_WIDTH  first operand, request N.
- reqN_data_2  in  DATA_WIDTH  second operand, request N.
- rspN_valid  out  1  response N holds a result.
- rspN_ready  in  1  requester N takes the response.
- rspN_result  out  DATA_WIDTH  registered ALU result.
- rspN_zero  out  1  registered ALU zero flag.
- alu_op  out  OP_WIDTH  to ALU op.
- alu_shamt  out  OP_WIDTH  to ALU shamt.
- alu_data_1  out  DATA_WIDTH  to ALU first operand.
- alu_data_2  out  DATA_WIDTH  to ALU second operand.
- alu_result  in  DATA_WIDTH  from ALU result.
- alu_zero  in  1  from ALU zero.
- busy  out  1  high in any state except IDLE.
- owner  out  1  index of requester currently served (valid when busy).

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset → IDLE.
- Reset values: alu_* outputs 0, result/zero registers 0, owner=0, last_grant=1 (so requester 0 wins first contention), rspN_valid=0, reqN_ready=0, busy=0.
- reqN_ready (combinational) = (state==IDLE) & winner==N & reqN_valid.
- Winner when both valid: requester != last_grant. Winner when one valid: that one.
- IDLE, any reqN_valid:
  - latch op, shamt, data_1, data_2 of winner into operand registers;
  - owner <= winner; last_grant <= winner; go EXEC.
- IDLE, no valid: stay. A request is accepted only on a cycle with valid & ready.
- EXEC (exactly one cycle):
  - alu_* outputs are driven from the operand registers (registered, stable the whole cycle; held at last value otherwise, 0 after reset);
  - capture alu_result/alu_zero into result registers at end of cycle; go RESP.
- RESP:
  - rsp[owner]_valid=1, other rsp valid=0; rspN_result/rspN_zero show the registers (both rsp data buses may show them; only valid qualifies).
  - On rsp[owner]_ready → IDLE. Otherwise hold indefinitely; result stable under backpressure.
- Latency: accept at cycle T → rsp valid at T+2 (ready held high). Back-to-back throughput: one op per 3 cycles; the next accept is possible on the cycle after the response handshake.
- Requests arriving while busy see ready=0 and must hold (standard valid-stays-asserted rule). The arbiter does not buffer them.
- Op codes outside the ALU's defined set are passed through unchanged; the ALU yields result 0, zero=1. No error signalling.
- Fairness: under continuous contention, grants alternate 0,1,0,1…
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded with no response; state returns to IDLE with all reset values; last_grant=1.
- Simultaneous rsp handshake and new reqN_valid in RESP: no accept that cycle; the accept happens in IDLE the following cycle.

Test Plan:
- Single op: rst, then req0 op=00000, d1=5, d2=7, rsp0_ready=1 → req0_ready at T; at T+1 alu_op=00000, alu_data_1=5, alu_data_2=7; rsp0_valid at T+2 with result=12, zero=0; rsp1_valid stays 0.
- Contention: req0 and req1 both valid continuously, req0 op=00001 (9-9), req1 op=01011 (0xF0|0x0F) → grants alternate 0,1,0. rsp0 gives result=0, zero=1; rsp1 gives result=0xFF.
- Backpressure: req1 op=00111, d1=1, shamt=4, rsp1_ready low for 5 cycles → rsp1_valid held, result=16 stable. req0_ready stays 0 throughout. Handshake on cycle 6 → IDLE, req0 accepted the next cycle.
- Reset mid-op: accept req0, assert rst during EXEC → no rsp0_valid ever. Outputs return to reset values; the next contention grants requester 0.
- Undefined op: req0 op=11111, d1=3 → rsp0 result=0, zero=1, latency 2.
- Divide-by-zero path: req1 op=00110, d1=20, d2=0 → rsp1 result=20 (ALU divides by 1).

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Bundles the two requester handshakes, their response channels and the shared ALU bus.
// Arbiter side is "slave"; the requesters plus ALU side is "master".
interface alu_share_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 5
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [OP_WIDTH-1:0]   req0_op;
  logic [OP_WIDTH-1:0]   req0_shamt;
  logic [DATA_WIDTH-1:0] req0_data_1;
  logic [DATA_WIDTH-1:0] req0_data_2;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [OP_WIDTH-1:0]   req1_op;
  logic [OP_WIDTH-1:0]   req1_shamt;
  logic [DATA_WIDTH-1:0] req1_data_1;
  logic [DATA_WIDTH-1:0] req1_data_2;

  logic                  rsp0_valid;
  logic                  rsp0_ready;
  logic [DATA_WIDTH-1:0] rsp0_result;
  logic                  rsp0_zero;

  logic                  rsp1_valid;
  logic                  rsp1_ready;
  logic [DATA_WIDTH-1:0] rsp1_result;
  logic                  rsp1_zero;

  logic [OP_WIDTH-1:0]   alu_op;
  logic [OP_WIDTH-1:0]   alu_shamt;
  logic [DATA_WIDTH-1:0] alu_data_1;
  logic [DATA_WIDTH-1:0] alu_data_2;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;

  modport slave (
    input  req0_valid, req0_op, req0_shamt, req0_data_1, req0_data_2,
    input  req1_valid, req1_op, req1_shamt, req1_data_1, req1_data_2,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero,
    output rsp1_valid, rsp1_result, rsp1_zero,
    input  rsp0_ready, rsp1_ready,
    output alu_op, alu_shamt, alu_data_1, alu_data_2,
    input  alu_result, alu_zero
  );

  modport master (
    output req0_valid, req0_op, req0_shamt, req0_data_1, req0_data_2,
    output req1_valid, req1_op, req1_shamt, req1_data_1, req1_data_2,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero,
    input  rsp1_valid, rsp1_result, rsp1_zero,
    output rsp0_ready, rsp1_ready,
    input  alu_op, alu_shamt, alu_data_1, alu_data_2,
    output alu_result, alu_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between two requesters with round-robin arbitration.
// Sequence per op: IDLE (accept) -> EXEC (ALU driven, result captured) -> RESP (held until taken).
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_share_arbiter_if.slave    bus,
  output logic                  busy,
  output logic                  owner,
  output logic [1:0]            fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Requesters keep valid and payload stable until ready; response valid stays high and
  // result/zero stay stable until the owning requester raises ready.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  logic                  last_grant;
  logic                  winner;
  logic                  any_valid;
  logic                  owner_rsp_ready;
  logic [OP_WIDTH-1:0]   op_q;
  logic [OP_WIDTH-1:0]   shamt_q;
  logic [DATA_WIDTH-1:0] data_1_q;
  logic [DATA_WIDTH-1:0] data_2_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  zero_q;

  // Under contention the requester not granted last time wins.
  always_comb begin
    winner = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      winner = ~last_grant;
    end else begin
      winner = bus.req1_valid;
    end
  end

  assign any_valid       = bus.req0_valid | bus.req1_valid;
  assign owner_rsp_ready = owner ? bus.rsp1_ready : bus.rsp0_ready;

  assign bus.req0_ready = (state == IDLE) && (winner == 1'b0) && bus.req0_valid;
  assign bus.req1_ready = (state == IDLE) && (winner == 1'b1) && bus.req1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      op_q       <= '0;
      shamt_q    <= '0;
      data_1_q   <= '0;
      data_2_q   <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            op_q       <= winner ? bus.req1_op     : bus.req0_op;
            shamt_q    <= winner ? bus.req1_shamt  : bus.req0_shamt;
            data_1_q   <= winner ? bus.req1_data_1 : bus.req0_data_1;
            data_2_q   <= winner ? bus.req1_data_2 : bus.req0_data_2;
            owner      <= winner;
            last_grant <= winner;
            state      <= EXEC;
          end
        end
        EXEC: begin
          result_q <= bus.alu_result;
          zero_q   <= bus.alu_zero;
          state    <= RESP;
        end
        RESP: begin
          if (owner_rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand registers feed the ALU directly, so its inputs hold their last values between ops.
  assign bus.alu_op     = op_q;
  assign bus.alu_shamt  = shamt_q;
  assign bus.alu_data_1 = data_1_q;
  assign bus.alu_data_2 = data_2_q;

  assign bus.rsp0_valid  = (state == RESP) && (owner == 1'b0);
  assign bus.rsp1_valid  = (state == RESP) && (owner == 1'b1);
  assign bus.rsp0_result = result_q;
  assign bus.rsp1_result = result_q;
  assign bus.rsp0_zero   = zero_q;
  assign bus.rsp1_zero   = zero_q;

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU on the shared bus.
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int OW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          busy;
  logic          owner;
  logic [1:0]    fsm_state;
  int            errors = 0;
  int            checks = 0;

  alu_share_arbiter_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus ();

  alu_share_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .busy      (busy),
    .owner     (owner),
    .fsm_state (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ALU stub: add, sub, div (by 1 when divisor 0), sll, or; anything else gives 0.
  always_comb begin
    case (bus.alu_op)
      5'b00000: bus.alu_result = bus.alu_data_1 + bus.alu_data_2;
      5'b00001: bus.alu_result = bus.alu_data_1 - bus.alu_data_2;
      5'b00110: bus.alu_result = bus.alu_data_1 / ((bus.alu_data_2 == '0) ? 32'd1 : bus.alu_data_2);
      5'b00111: bus.alu_result = bus.alu_data_1 << bus.alu_shamt;
      5'b01011: bus.alu_result = bus.alu_data_1 | bus.alu_data_2;
      default:  bus.alu_result = '0;
    endcase
    bus.alu_zero = (bus.alu_result == '0);
  end

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_req(input int idx, input logic v, input logic [OW-1:0] op,
                           input logic [OW-1:0] sh, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    if (idx == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_shamt = sh;
      bus.req0_data_1 = d1; bus.req0_data_2 = d2;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_shamt = sh;
      bus.req1_data_1 = d1; bus.req1_data_2 = d2;
    end
  endtask

  // One uncontended op with response ready high: accept at T, ALU at T+1, response at T+2.
  task automatic do_op(input string tag, input int idx, input logic [OW-1:0] op, input logic [OW-1:0] sh,
                       input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                       input logic [DW-1:0] exp_res, input logic exp_zero);
    drive_req(idx, 1'b1, op, sh, d1, d2);
    sample();
    check_eq({tag, "_ready"}, (idx == 0) ? bus.req0_ready : bus.req1_ready, 1);
    tick();
    drive_req(idx, 1'b0, '0, '0, '0, '0);
    sample();
    check_eq({tag, "_alu_op"}, bus.alu_op, op);
    check_eq({tag, "_alu_d1"}, bus.alu_data_1, d1);
    check_eq({tag, "_alu_d2"}, bus.alu_data_2, d2);
    check_eq({tag, "_owner"}, owner, idx);
    check_eq({tag, "_early_valid"}, bus.rsp0_valid | bus.rsp1_valid, 0);
    tick();
    sample();
    check_eq({tag, "_rsp_valid"}, (idx == 0) ? bus.rsp0_valid : bus.rsp1_valid, 1);
    check_eq({tag, "_other_valid"}, (idx == 0) ? bus.rsp1_valid : bus.rsp0_valid, 0);
    check_eq({tag, "_result"}, (idx == 0) ? bus.rsp0_result : bus.rsp1_result, exp_res);
    check_eq({tag, "_zero"}, (idx == 0) ? bus.rsp0_zero : bus.rsp1_zero, exp_zero);
    tick();
    sample();
    check_eq({tag, "_idle"}, busy, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_owner;
    rst = 1'b1;
    drive_req(0, 1'b0, '0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0, '0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    sample();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_owner", owner, 0);
    check_eq("rst_state", fsm_state, 0);
    check_eq("rst_alu_op", bus.alu_op, 0);
    check_eq("rst_alu_d1", bus.alu_data_1, 0);
    check_eq("rst_rsp0_valid", bus.rsp0_valid, 0);
    check_eq("rst_rsp1_valid", bus.rsp1_valid, 0);
    check_eq("rst_req0_ready", bus.req0_ready, 0);
    tick();

    // contention: grants alternate 0,1,0
    drive_req(0, 1'b1, 5'b00001, '0, 32'd9, 32'd9);
    drive_req(1, 1'b1, 5'b01011, '0, 32'hF0, 32'h0F);
    for (int g = 0; g < 3; g++) begin
      exp_owner = g % 2;
      sample();
      check_eq("cont_req0_ready", bus.req0_ready, (exp_owner == 0) ? 1 : 0);
      check_eq("cont_req1_ready", bus.req1_ready, (exp_owner == 1) ? 1 : 0);
      tick();
      if (g == 2) begin
        drive_req(0, 1'b0, '0, '0, '0, '0);
        drive_req(1, 1'b0, '0, '0, '0, '0);
      end
      sample();
      check_eq("cont_owner", owner, exp_owner);
      check_eq("cont_busy", busy, 1);
      tick();
      sample();
      if (exp_owner == 0) begin
        check_eq("cont_rsp0_valid", bus.rsp0_valid, 1);
        check_eq("cont_rsp0_result", bus.rsp0_result, 0);
        check_eq("cont_rsp0_zero", bus.rsp0_zero, 1);
      end else begin
        check_eq("cont_rsp1_valid", bus.rsp1_valid, 1);
        check_eq("cont_rsp1_result", bus.rsp1_result, 32'hFF);
        check_eq("cont_rsp1_zero", bus.rsp1_zero, 0);
      end
      tick();
    end

    // backpressure on rsp1 while req0 waits (last grant was 0, so req1 wins)
    bus.rsp1_ready = 1'b0;
    drive_req(0, 1'b1, 5'b00000, '0, 32'd2, 32'd3);
    drive_req(1, 1'b1, 5'b00111, 5'd4, 32'd1, 32'd0);
    sample();
    check_eq("bp_req1_ready", bus.req1_ready, 1);
    check_eq("bp_req0_ready_idle", bus.req0_ready, 0);
    tick();
    drive_req(1, 1'b0, '0, '0, '0, '0);
    sample();
    check_eq("bp_alu_shamt", bus.alu_shamt, 4);
    check_eq("bp_req0_ready_exec", bus.req0_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      sample();
      check_eq("bp_rsp1_valid", bus.rsp1_valid, 1);
      check_eq("bp_rsp1_result", bus.rsp1_result, 32'd16);
      check_eq("bp_req0_ready", bus.req0_ready, 0);
      tick();
    end
    bus.rsp1_ready = 1'b1;
    sample();
    check_eq("bp_rsp1_valid_last", bus.rsp1_valid, 1);
    check_eq("bp_rsp1_result_last", bus.rsp1_result, 32'd16);
    tick();
    sample();
    check_eq("bp_req0_accept", bus.req0_ready, 1);
    tick();
    drive_req(0, 1'b0, '0, '0, '0, '0);
    tick();
    sample();
    check_eq("bp_rsp0_valid", bus.rsp0_valid, 1);
    check_eq("bp_rsp0_result", bus.rsp0_result, 32'd5);
    tick();

    // reset during EXEC discards the op
    drive_req(0, 1'b1, 5'b00000, '0, 32'd1, 32'd1);
    sample();
    check_eq("rmid_ready", bus.req0_ready, 1);
    tick();
    drive_req(0, 1'b0, '0, '0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      check_eq("rmid_rsp0_valid", bus.rsp0_valid, 0);
      check_eq("rmid_busy", busy, 0);
      check_eq("rmid_alu_d1", bus.alu_data_1, 0);
      check_eq("rmid_owner", owner, 0);
      tick();
    end
    drive_req(0, 1'b1, 5'b00000, '0, 32'd4, 32'd4);
    drive_req(1, 1'b1, 5'b00000, '0, 32'd7, 32'd7);
    sample();
    check_eq("rmid_cont_req0", bus.req0_ready, 1);
    check_eq("rmid_cont_req1", bus.req1_ready, 0);
    tick();
    drive_req(0, 1'b0, '0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0, '0);
    tick();
    sample();
    check_eq("rmid_rsp0_result", bus.rsp0_result, 32'd8);
    tick();

    // single op, undefined op, divide by zero
    do_op("add", 0, 5'b00000, '0, 32'd5, 32'd7, 32'd12, 1'b0);
    do_op("undef", 0, 5'b11111, '0, 32'd3, 32'd0, 32'd0, 1'b1);
    do_op("div0", 1, 5'b00110, '0, 32'd20, 32'd0, 32'd20, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
